slot_score_engine: RTL



---
 rtl/slot_score_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/slot_score_engine.sv
`default_nettype none
// ============================================================================
//  Module      : slot_score_engine
//  Description : Credit/scoring core for a REELS-reel one-arm bandit. Deducts
//                the bet on a spin, walks the latched symbols one adjacent
//                pair per cycle, adds a saturating pair/jackpot payout and
//                flags pass/lose game end.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_score_engine #(
    parameter int REELS       = 3,
    parameter int SYM_W       = 4,
    parameter int SCORE_W     = 8,
    parameter int INIT_SCORE  = 10,
    parameter int BET         = 1,
    parameter int PAIR_PAY    = 2,
    parameter int JACKPOT_PAY = 10,
    parameter int PASS_SCORE  = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     turn_p,
    input  logic                     score_sign,
    input  logic [REELS*SYM_W-1:0]   symbols,
    input  logic                     new_game,
    output logic [SCORE_W-1:0]       number,
    output logic [1:0]               win_code,
    output logic                     busy,
    output logic                     game_over,
    output logic                     pass_p,
    output logic                     lose_p
);

    // Index/pair counter width: both never exceed REELS-1.
    localparam int CNT_W = (REELS > 2) ? $clog2(REELS) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SPIN   = 3'd1;
    localparam logic [2:0] c_EVAL   = 3'd2;
    localparam logic [2:0] c_PAYOUT = 3'd3;
    localparam logic [2:0] c_OVER   = 3'd4;

    localparam logic [1:0] c_WIN_NONE = 2'd0;
    localparam logic [1:0] c_WIN_PAIR = 2'd1;
    localparam logic [1:0] c_WIN_JACK = 2'd2;

    localparam logic [SCORE_W-1:0] c_INIT = SCORE_W'(INIT_SCORE);
    localparam logic [SCORE_W-1:0] c_BET  = SCORE_W'(BET);
    localparam logic [SCORE_W-1:0] c_PASS = SCORE_W'(PASS_SCORE);
    localparam logic [SCORE_W-1:0] c_MAX  = '1;
    localparam logic [SCORE_W:0]   c_JACK_PAY = (SCORE_W+1)'(JACKPOT_PAY);
    localparam logic [SCORE_W:0]   c_PAIR_PAY = (SCORE_W+1)'(PAIR_PAY);
    localparam logic [CNT_W-1:0]   c_LAST_IDX = CNT_W'(REELS-2);
    localparam logic [CNT_W-1:0]   c_ALL_PAIRS = CNT_W'(REELS-1);
    localparam logic [CNT_W-1:0]   c_ONE = CNT_W'(1);

    logic [2:0]             state_q,  state_d;
    logic [SCORE_W-1:0]     number_q, number_d;
    logic [1:0]             win_q,    win_d;
    logic                   busy_q,   busy_d;
    logic                   over_q,   over_d;
    logic                   pass_q,   pass_d;
    logic                   lose_q,   lose_d;
    logic [REELS*SYM_W-1:0] sym_q,    sym_d;
    logic [CNT_W-1:0]       idx_q,    idx_d;
    logic [CNT_W-1:0]       pairs_q,  pairs_d;

    // Latched symbols viewed as one entry per reel.
    logic [SYM_W-1:0]       w_reel [REELS];

    generate
        for (genvar g = 0; g < REELS; g++) begin : g_reel
            assign w_reel[g] = sym_q[g*SYM_W +: SYM_W];
        end
    endgenerate

    logic [SCORE_W:0]       w_pay;
    logic [1:0]             w_win;
    logic [SCORE_W:0]       w_sum;
    logic [SCORE_W-1:0]     w_new;

    // Payout class from the accumulated adjacent-pair count, with saturating add.
    always_comb begin
        if (pairs_q == c_ALL_PAIRS) begin
            w_pay = c_JACK_PAY;
            w_win = c_WIN_JACK;
        end else if (pairs_q != '0) begin
            w_pay = c_PAIR_PAY;
            w_win = c_WIN_PAIR;
        end else begin
            w_pay = '0;
            w_win = c_WIN_NONE;
        end
        w_sum = {1'b0, number_q} + w_pay;
        w_new = w_sum[SCORE_W] ? c_MAX : w_sum[SCORE_W-1:0];
    end

    // Next-state logic; new_game overrides whatever the current state decided.
    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        win_d    = win_q;
        pass_d   = 1'b0;
        lose_d   = 1'b0;
        sym_d    = sym_q;
        idx_d    = idx_q;
        pairs_d  = pairs_q;

        case (state_q)
            c_IDLE: begin
                if (turn_p && (number_q >= c_BET)) begin
                    number_d = number_q - c_BET;
                    win_d    = c_WIN_NONE;
                    state_d  = c_SPIN;
                end
            end
            c_SPIN: begin
                if (score_sign) begin
                    sym_d   = symbols;
                    idx_d   = '0;
                    pairs_d = '0;
                    state_d = c_EVAL;
                end
            end
            c_EVAL: begin
                // One adjacent comparison per cycle; REELS-1 cycles in total.
                if (w_reel[idx_q] == w_reel[idx_q + c_ONE]) begin
                    pairs_d = pairs_q + c_ONE;
                end
                idx_d = idx_q + c_ONE;
                if (idx_q == c_LAST_IDX) begin
                    state_d = c_PAYOUT;
                end
            end
            c_PAYOUT: begin
                number_d = w_new;
                win_d    = w_win;
                if (w_new >= c_PASS) begin
                    pass_d  = 1'b1;
                    state_d = c_OVER;
                end else if (w_new < c_BET) begin
                    lose_d  = 1'b1;
                    state_d = c_OVER;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_OVER: begin
                state_d = c_OVER;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Restart aborts any spin in flight: no payout, no refund.
        if (new_game) begin
            state_d  = c_IDLE;
            number_d = c_INIT;
            win_d    = c_WIN_NONE;
            pass_d   = 1'b0;
            lose_d   = 1'b0;
        end

        busy_d = (state_d == c_SPIN) || (state_d == c_EVAL) || (state_d == c_PAYOUT);
        over_d = (state_d == c_OVER);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_IDLE;
            number_q <= c_INIT;
            win_q    <= c_WIN_NONE;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
            pass_q   <= 1'b0;
            lose_q   <= 1'b0;
            sym_q    <= '0;
            idx_q    <= '0;
            pairs_q  <= '0;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
            pass_q   <= pass_d;
            lose_q   <= lose_d;
            sym_q    <= sym_d;
            idx_q    <= idx_d;
            pairs_q  <= pairs_d;
        end
    end

    assign number    = number_q;
    assign win_code  = win_q;
    assign busy      = busy_q;
    assign game_over = over_q;
    assign pass_p    = pass_q;
    assign lose_p    = lose_q;

endmodule
`default_nettype wire
